// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and the control-word bundle
// for the multi-cycle control sequencer.
package cpu_ctrl_pkg;

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_FETCH_L = 3'd1;
  localparam logic [2:0] S_FETCH_H = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_BRA = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_STL = 4'h5;
  localparam logic [3:0] OP_LDL = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] RF_LOAD = 3'b010;

  localparam logic [2:0] ARF_DEC  = 3'b000;
  localparam logic [2:0] ARF_INC  = 3'b001;
  localparam logic [2:0] ARF_LOAD = 3'b010;
  localparam logic [2:0] ARF_CLR  = 3'b011;

  localparam logic [2:0] ARF_PC = 3'b100;
  localparam logic [2:0] ARF_SP = 3'b010;
  localparam logic [2:0] ARF_AR = 3'b001;

  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD   = 5'b10100;
  localparam logic [4:0] ALU_SUB   = 5'b10110;

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_OUTC = 2'b01;
  localparam logic [1:0] MUX_MEM  = 2'b10;
  localparam logic [1:0] MUX_IMM  = 2'b11;

  localparam logic [1:0] OUTD_PC = 2'b00;
  localparam logic [1:0] OUTD_SP = 2'b01;
  localparam logic [1:0] OUTD_AR = 2'b10;

  typedef struct packed {
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_wr;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

  function automatic logic [3:0] rf_onehot(logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

  function automatic logic op_defined(logic [3:0] op);
    return (op <= OP_BEQ) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle: IR/flags in, all
// control selects and enables out.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic        Halted;
  logic        Illegal;

  modport master (
    input  IROut, FlagsOut,
    output RF_OutASel, RF_OutBSel, RF_FunSel,
    output RF_RegSel, RF_ScrSel,
    output ALU_FunSel, ALU_WF,
    output ARF_OutCSel, ARF_OutDSel,
    output ARF_FunSel, ARF_RegSel,
    output IR_LH, IR_Write, Mem_WR, Mem_CS,
    output MuxASel, MuxBSel, MuxCSel,
    output Halted, Illegal
  );

  modport slave (
    output IROut, FlagsOut,
    input  RF_OutASel, RF_OutBSel, RF_FunSel,
    input  RF_RegSel, RF_ScrSel,
    input  ALU_FunSel, ALU_WF,
    input  ARF_OutCSel, ARF_OutDSel,
    input  ARF_FunSel, ARF_RegSel,
    input  IR_LH, IR_Write, Mem_WR, Mem_CS,
    input  MuxASel, MuxBSel, MuxCSel,
    input  Halted, Illegal
  );
endinterface

// File: rtl/control_decode.sv
// Combinational map from (state, IR, flags)
// to the full control word.
module control_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int         OPW      = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic [2:0]  state,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output ctrl_t       ctrl
);

  logic [OPW-1:0] op;
  logic [1:0]     rd;
  logic [1:0]     rs1;
  logic [1:0]     rs2;
  logic           unused;

  assign op     = ir[15 -: OPW];
  assign rd     = ir[11:10];
  assign rs1    = ir[9:8];
  assign rs2    = ir[7:6];
  assign unused = ^{flags[2:0], ir[5:0]};

  always_comb begin
    ctrl = CTRL_IDLE;
    unique case (1'b1)
      state == S_INIT: begin
        ctrl.arf_reg = ARF_PC;
        if (RESET_PC == 8'h00) begin
          ctrl.arf_fun = ARF_CLR;
        end else begin
          ctrl.arf_fun = ARF_LOAD;
          ctrl.mux_b   = MUX_IMM;
        end
      end
      state == S_FETCH_L,
      state == S_FETCH_H: begin
        ctrl.outd    = OUTD_PC;
        ctrl.mem_cs  = 1'b0;
        ctrl.ir_wr   = 1'b1;
        ctrl.ir_lh   = (state == S_FETCH_H);
        ctrl.arf_reg = ARF_PC;
        ctrl.arf_fun = ARF_INC;
      end
      state == S_DECODE: begin
        ctrl.illegal = !op_defined(op);
      end
      state == S_EXEC: begin
        unique case (op)
          OP_BRA: begin
            ctrl.mux_b   = MUX_IMM;
            ctrl.arf_reg = ARF_PC;
            ctrl.arf_fun = ARF_LOAD;
          end
          OP_LDI: begin
            ctrl.mux_a  = MUX_IMM;
            ctrl.rf_fun = RF_LOAD;
            ctrl.rf_reg = rf_onehot(rd);
          end
          OP_ADD, OP_SUB: begin
            ctrl.a_sel   = {1'b0, rs1};
            ctrl.b_sel   = {1'b0, rs2};
            ctrl.alu_fun = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
            ctrl.alu_wf  = 1'b1;
            ctrl.mux_a   = MUX_ALU;
            ctrl.rf_fun  = RF_LOAD;
            ctrl.rf_reg  = rf_onehot(rd);
          end
          OP_STL: begin
            ctrl.a_sel   = {1'b0, rs1};
            ctrl.alu_fun = ALU_PASSA;
            ctrl.mux_c   = 1'b0;
            ctrl.outd    = OUTD_AR;
            ctrl.mem_cs  = 1'b0;
            ctrl.mem_wr  = 1'b1;
          end
          OP_LDL: begin
            ctrl.outd   = OUTD_AR;
            ctrl.mem_cs = 1'b0;
            ctrl.mux_a  = MUX_MEM;
            ctrl.rf_fun = RF_LOAD;
            ctrl.rf_reg = rf_onehot(rd);
          end
          OP_BEQ: begin
            if (flags[3]) begin
              ctrl.mux_b   = MUX_IMM;
              ctrl.arf_reg = ARF_PC;
              ctrl.arf_fun = ARF_LOAD;
            end
          end
          default: ;
        endcase
      end
      state == S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute FSM driving the datapath
// control lines; stops in HALT on HLT.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int         OPW      = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic                 Clock,
  input logic                 Reset,
  control_sequencer_if.master bus
);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [OPW-1:0] op;
  ctrl_t          dec;
  ctrl_t          ctrl;

  assign op = bus.IROut[15 -: OPW];

  control_decode #(
    .OPW      (OPW),
    .RESET_PC (RESET_PC)
  ) u_decode (
    .state (state),
    .ir    (bus.IROut),
    .flags (bus.FlagsOut),
    .ctrl  (dec)
  );

  always_comb begin
    state_nxt = S_INIT;
    unique case (1'b1)
      state == S_INIT:    state_nxt = S_FETCH_L;
      state == S_FETCH_L: state_nxt = S_FETCH_H;
      state == S_FETCH_H: state_nxt = S_DECODE;
      state == S_DECODE: begin
        if (op == OP_HLT)         state_nxt = S_HALT;
        else if (!op_defined(op)) state_nxt = S_FETCH_L;
        else                      state_nxt = S_EXEC;
      end
      state == S_EXEC:    state_nxt = S_FETCH_L;
      state == S_HALT:    state_nxt = S_HALT;
      default:            state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Holding reset masks the decoder so no write escapes an aborted instruction.
  assign ctrl = Reset ? dec : CTRL_IDLE;

  assign bus.RF_OutASel  = ctrl.a_sel;
  assign bus.RF_OutBSel  = ctrl.b_sel;
  assign bus.RF_FunSel   = ctrl.rf_fun;
  assign bus.RF_RegSel   = ctrl.rf_reg;
  assign bus.RF_ScrSel   = ctrl.rf_scr;
  assign bus.ALU_FunSel  = ctrl.alu_fun;
  assign bus.ALU_WF      = ctrl.alu_wf;
  assign bus.ARF_OutCSel = ctrl.outc;
  assign bus.ARF_OutDSel = ctrl.outd;
  assign bus.ARF_FunSel  = ctrl.arf_fun;
  assign bus.ARF_RegSel  = ctrl.arf_reg;
  assign bus.IR_LH       = ctrl.ir_lh;
  assign bus.IR_Write    = ctrl.ir_wr;
  assign bus.Mem_WR      = ctrl.mem_wr;
  assign bus.Mem_CS      = ctrl.mem_cs;
  assign bus.MuxASel     = ctrl.mux_a;
  assign bus.MuxBSel     = ctrl.mux_b;
  assign bus.MuxCSel     = ctrl.mux_c;
  assign bus.Halted      = ctrl.halted;
  assign bus.Illegal     = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus
// queues hand-written control words, monitor compares.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_wr;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic       illegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer #(
    .OPW      (4),
    .RESET_PC (8'h00)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  vec_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  function automatic vec_t idle_v();
    vec_t v = '0;
    v.mem_cs = 1'b1;
    return v;
  endfunction

  function automatic vec_t init_v();
    vec_t v = idle_v();
    v.arf_reg = 3'b100;
    v.arf_fun = 3'b011;
    return v;
  endfunction

  function automatic vec_t fetch_v(logic hi);
    vec_t v = idle_v();
    v.outd    = 2'b00;
    v.mem_cs  = 1'b0;
    v.ir_wr   = 1'b1;
    v.ir_lh   = hi;
    v.arf_reg = 3'b100;
    v.arf_fun = 3'b001;
    return v;
  endfunction

  function automatic vec_t act_v();
    vec_t v;
    v.a_sel   = bus.RF_OutASel;
    v.b_sel   = bus.RF_OutBSel;
    v.rf_fun  = bus.RF_FunSel;
    v.rf_reg  = bus.RF_RegSel;
    v.rf_scr  = bus.RF_ScrSel;
    v.alu_fun = bus.ALU_FunSel;
    v.alu_wf  = bus.ALU_WF;
    v.outc    = bus.ARF_OutCSel;
    v.outd    = bus.ARF_OutDSel;
    v.arf_fun = bus.ARF_FunSel;
    v.arf_reg = bus.ARF_RegSel;
    v.ir_lh   = bus.IR_LH;
    v.ir_wr   = bus.IR_Write;
    v.mem_wr  = bus.Mem_WR;
    v.mem_cs  = bus.Mem_CS;
    v.mux_a   = bus.MuxASel;
    v.mux_b   = bus.MuxBSel;
    v.mux_c   = bus.MuxCSel;
    v.halted  = bus.Halted;
    v.illegal = bus.Illegal;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [15:0] ir,
                     input logic [3:0] fl, input vec_t e,
                     input string nm);
    @(posedge clk);
    #1;
    rst          = r;
    bus.IROut    = ir;
    bus.FlagsOut = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic run(input logic [15:0] ir, input logic [3:0] fl,
                     input vec_t ex, input string nm);
    cyc(1'b1, ir, 4'h0, fetch_v(1'b0), {nm, "_fl"});
    cyc(1'b1, ir, 4'h0, fetch_v(1'b1), {nm, "_fh"});
    cyc(1'b1, ir, fl, idle_v(), {nm, "_dec"});
    cyc(1'b1, ir, fl, ex, {nm, "_ex"});
  endtask

  task automatic run_ill(input logic [15:0] ir, input string nm);
    vec_t e = idle_v();
    e.illegal = 1'b1;
    cyc(1'b1, ir, 4'h0, fetch_v(1'b0), {nm, "_fl"});
    cyc(1'b1, ir, 4'h0, fetch_v(1'b1), {nm, "_fh"});
    cyc(1'b1, ir, 4'h0, e, {nm, "_dec"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      vec_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = act_v();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    bus.IROut    = 16'h0000;
    bus.FlagsOut = 4'h0;
    rst          = 1'b0;

    cyc(1'b0, 16'h0000, 4'h0, idle_v(), "rst_a");
    cyc(1'b0, 16'h0000, 4'h0, idle_v(), "rst_b");
    cyc(1'b1, 16'h0000, 4'h0, init_v(), "init");

    e = idle_v(); e.mux_a = 2'b11; e.rf_fun = 3'b010;
    e.rf_reg = 4'b0001;
    run(16'h2C5A, 4'h0, e, "ldi");

    e = idle_v(); e.a_sel = 3'b010; e.b_sel = 3'b001;
    e.alu_fun = 5'b10100; e.alu_wf = 1'b1; e.mux_a = 2'b00;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
    run(16'h3640, 4'h0, e, "add");

    e = idle_v(); e.a_sel = 3'b010; e.b_sel = 3'b010;
    e.alu_fun = 5'b10110; e.alu_wf = 1'b1;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0001;
    run(16'h4E80, 4'h0, e, "sub");

    e = idle_v(); e.mux_b = 2'b11; e.arf_reg = 3'b100;
    e.arf_fun = 3'b010;
    run(16'h7012, 4'b1000, e, "beq_t");
    run(16'h1034, 4'h0, e, "bra");
    run(16'h7012, 4'b0000, idle_v(), "beq_nt");
    run(16'h7012, 4'b0111, idle_v(), "beq_nz");
    run(16'h0000, 4'h0, idle_v(), "nop");

    e = idle_v(); e.outd = 2'b10; e.mem_cs = 1'b0;
    e.mux_a = 2'b10; e.rf_fun = 3'b010; e.rf_reg = 4'b0010;
    run(16'h6800, 4'h0, e, "ldl");

    e = idle_v(); e.a_sel = 3'b001; e.alu_fun = 5'b10000;
    e.outd = 2'b10; e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    run(16'h5100, 4'h0, e, "stl");

    run_ill(16'h9000, "ill9");
    run_ill(16'hE000, "illE");
    run_ill(16'h8000, "ill8");

    e = idle_v(); e.mux_a = 2'b11; e.rf_fun = 3'b010;
    e.rf_reg = 4'b1000;
    run(16'h20FF, 4'h0, e, "ldi_r1");

    cyc(1'b1, 16'h5100, 4'h0, fetch_v(1'b0), "stlr_fl");
    cyc(1'b1, 16'h5100, 4'h0, fetch_v(1'b1), "stlr_fh");
    cyc(1'b1, 16'h5100, 4'h0, idle_v(), "stlr_dec");
    cyc(1'b0, 16'h5100, 4'h0, idle_v(), "stlr_ex_rst");
    cyc(1'b1, 16'h5100, 4'h0, init_v(), "stlr_init");

    cyc(1'b1, 16'hF000, 4'h0, fetch_v(1'b0), "hlt_fl");
    cyc(1'b1, 16'hF000, 4'h0, fetch_v(1'b1), "hlt_fh");
    cyc(1'b1, 16'hF000, 4'h0, idle_v(), "hlt_dec");
    e = idle_v(); e.halted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'hF000, 4'hF, e, $sformatf("halt_%0d", i));
    end
    cyc(1'b0, 16'hF000, 4'h0, idle_v(), "halt_rst");
    cyc(1'b1, 16'h0000, 4'h0, init_v(), "halt_init");
    cyc(1'b1, 16'h0000, 4'h0, fetch_v(1'b0), "halt_fl");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream control stage of the CPU datapath: a multi-cycle fetch/decode/execute FSM that drives every control input of the ALU system (register file, ALU, address register file, IR, memory, muxes).
- Consumes the datapath's IROut and FlagsOut; produces all select/enable lines each cycle.
- Implements an 8-instruction subset and stops in a HALT state on HLT.

Parameters:
- OPW, 4, opcode width (IROut[15:12]).
- RESET_PC, 8'h00, value loaded into PC during INIT (zero-extended to 16 bits).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- IROut  in  16  instruction register contents.
- FlagsOut  in  4  {Z,C,N,O} from ALU.
- RF_OutASel, RF_OutBSel  out  3 each  R1..R4 = 000..011.
- RF_FunSel  out  3  010 = load.
- RF_RegSel  out  4  one-hot write enable; [3]=R1, [2]=R2, [1]=R3, [0]=R4.
- RF_ScrSel  out  4  always 0.
- ALU_FunSel  out  5  10000 = pass A, 10100 = add, 10110 = sub.
- ALU_WF  out  1  flag write.
- ARF_OutCSel  out  2  always 00.
- ARF_OutDSel  out  2  address source; 00 = PC, 01 = SP, 10 = AR.
- ARF_FunSel  out  3  000 = dec, 001 = inc, 010 = load, 011 = clear.
- ARF_RegSel  out  3  one-hot; [2]=PC, [1]=SP, [0]=AR.
- IR_LH  out  1  0 = low byte, 1 = high byte.
- IR_Write  out  1
- Mem_WR  out  1  1 = write.
- Mem_CS  out  1  active-low select.
- MuxASel, MuxBSel  out  2 each  00 = ALU, 01 = OutC, 10 = Mem, 11 = IR[7:0].
- MuxCSel  out  1
- Halted  out  1  high in HALT.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Idle output values apply in every state unless overridden: all enables and selects 0, Mem_CS = 1.
- While Reset = 0, outputs are forced idle. On the clock edge with Reset = 0, state <= INIT.
- Reset asserted mid-instruction aborts it; no partial write occurs after that edge.
- Outputs are combinational from the state register and IROut.
- Instruction fields:
  - op = IR[15:12]
  - Rd = IR[11:10]
  - Rs1 = IR[9:8]
  - Rs2 = IR[7:6]
  - imm = IR[7:0]
- States and transitions:
  - INIT: ARF_RegSel = 100. If RESET_PC == 0: ARF_FunSel = clear. Otherwise: load via MuxBSel = 11 — not valid before any fetch, so RESET_PC != 0 is unsupported in this revision. -> FETCH_L.
  - FETCH_L: ARF_OutDSel = PC, Mem_CS = 0, Mem_WR = 0, IR_Write = 1, IR_LH = 0, ARF_RegSel = 100, ARF_FunSel = inc. -> FETCH_H.
  - FETCH_H: same as FETCH_L but IR_LH = 1. -> DECODE.
  - DECODE: no outputs. Undefined op: Illegal = 1, -> FETCH_L. HLT: -> HALT. Otherwise -> EXEC.
  - EXEC, by op:
    - 0 NOP: nothing.
    - 1 BRA: MuxBSel = 11, ARF load PC.
    - 2 LDI: MuxASel = 11, RF load Rd.
    - 3 ADD: OutASel = Rs1, OutBSel = Rs2, ALU add, WF = 1, MuxASel = 00, RF load Rd.
    - 4 SUB: as ADD with sub.
    - 5 STL: OutASel = Rs1, ALU pass A, MuxCSel = 0, OutDSel = AR, Mem_CS = 0, Mem_WR = 1.
    - 6 LDL: OutDSel = AR, Mem_CS = 0, MuxASel = 10, RF load Rd.
    - 7 BEQ: if FlagsOut[3] then as BRA, else nothing.
    - F HLT is handled in DECODE.
    - 8–E are undefined.
    - Next state -> FETCH_L.
  - HALT: idle outputs, Halted = 1. Leaves only on reset.
- Latency: 4 cycles per executed instruction; 3 cycles for undefined opcodes.
- Flags sampled by BEQ are those at the EXEC cycle.
- PC increments by 1 per fetched byte. PC wraps 16'hFFFF -> 0000; this wrap is owned by the ARF.
- BRA/BEQ load the zero-extended imm into PC.

Decomposition:
- Package cpu_ctrl_pkg: state enum; opcode constants; RF/ARF/ALU FunSel codes; mux select codes; OutDSel codes; idle-default constant.
- One sub-module, control_decode: combinational (state, IROut, FlagsOut) -> control outputs.
- The FSM register and next-state logic stay in control_sequencer.

Test Plan:
- Reset low 2 cycles, then high -> INIT: ARF_RegSel = 100, FunSel = 011. Next cycle FETCH_L: IR_Write = 1, IR_LH = 0, Mem_CS = 0, ARF inc PC.
- IROut = 16'h2C5A (LDI R4, 5A) -> EXEC (4th cycle): MuxASel = 11, RF_FunSel = 010, RF_RegSel = 0001; then FETCH_L.
- IROut = 16'h3640 (ADD R2 = R3 + R2) -> EXEC: OutASel = 010, OutBSel = 001, ALU_FunSel = 10100, ALU_WF = 1, RF_RegSel = 0100.
- IROut = 16'h7012:
  - FlagsOut = 4'b1000 -> EXEC: MuxBSel = 11, ARF_RegSel = 100, FunSel = 010.
  - FlagsOut = 0 -> EXEC all idle.
- IROut = 16'h9000 -> DECODE: Illegal = 1 for exactly 1 cycle; next state FETCH_L; no RF/ARF/Mem write.
- IROut = 16'hF000 -> HALT: Halted = 1, Mem_CS = 1 held for 10 cycles. Reset low for 1 cycle -> INIT.
- Reset low during EXEC of STL -> no Mem_WR = 1 on the following cycle.
